// File: rtl/jedro_1_defines.sv
// Shared jedro_1 defaults and the requester tag used to route ROM read data.
package jedro_1_defines;

  localparam int          DATA_WIDTH = 32;
  localparam logic [31:0] BOOT_ADDR  = 32'h0000_0000;
  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_SIZE   = 32'h0000_1000;

  typedef enum logic [1:0] {
    TAG_NONE = 2'b00,
    TAG_IFU  = 2'b01,
    TAG_LSU  = 2'b10,
    TAG_ERR  = 2'b11
  } tag_e;

endpackage

// File: rtl/jedro_1_prio_starve.sv
// Two-input priority select (LSU first) with a saturating starvation counter
// that forces the IFU ahead after MAX_WAIT consecutive denials.
module jedro_1_prio_starve #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ifu_req,
  input  logic lsu_req,
  output logic ifu_gnt,
  output logic lsu_gnt
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] wait_cnt;
  logic          force_ifu;

  assign force_ifu = (wait_cnt == CW'(MAX_WAIT));

  always_comb begin
    ifu_gnt = !rst && ifu_req && (!lsu_req || force_ifu);
    lsu_gnt = !rst && lsu_req && !ifu_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (!ifu_req || ifu_gnt) begin
      wait_cnt <= '0;
    end else if (!force_ifu) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jedro_1_imem_arbiter.sv
// Shares the single-port instruction ROM between fetch and an LSU load port;
// one grant per cycle, the in-flight read is tagged and data routed to its owner.
module jedro_1_imem_arbiter
  import jedro_1_defines::*;
#(
  parameter int                    DATA_WIDTH = jedro_1_defines::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] ROM_BASE   = jedro_1_defines::ROM_BASE,
  parameter logic [DATA_WIDTH-1:0] ROM_SIZE   = jedro_1_defines::ROM_SIZE,
  parameter int                    MAX_WAIT   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ifu_req_i,
  input  logic [DATA_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_gnt_o,
  output logic                  ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                  lsu_req_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  output logic                  mem_rst_o,
  output logic                  mem_en_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i
);

  logic [DATA_WIDTH-1:0] ifu_off, lsu_off, ifu_word, lsu_word;
  logic [DATA_WIDTH-1:0] addr_q, ifu_hold, lsu_hold;
  logic                  lsu_in_range, lsu_mem;
  tag_e                  tag_q;

  jedro_1_prio_starve #(.MAX_WAIT(MAX_WAIT)) u_prio (
    .clk     (clk_i),
    .rst     (rst_i),
    .ifu_req (ifu_req_i),
    .lsu_req (lsu_req_i),
    .ifu_gnt (ifu_gnt_o),
    .lsu_gnt (lsu_gnt_o)
  );

  // Offsets wrap for addresses below ROM_BASE, so one unsigned compare covers both bounds.
  assign ifu_off      = ifu_addr_i - ROM_BASE;
  assign lsu_off      = lsu_addr_i - ROM_BASE;
  assign ifu_word     = (ifu_off & (ROM_SIZE - 1'b1)) >> 2;
  assign lsu_word     = (lsu_off & (ROM_SIZE - 1'b1)) >> 2;
  assign lsu_in_range = (lsu_off < ROM_SIZE);
  assign lsu_mem      = lsu_gnt_o && lsu_in_range;

  assign mem_rst_o  = rst_i;
  assign mem_en_o   = ifu_gnt_o || lsu_mem;
  assign mem_addr_o = ifu_gnt_o ? ifu_word : (lsu_mem ? lsu_word : addr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q    <= TAG_NONE;
      addr_q   <= '0;
      ifu_hold <= '0;
      lsu_hold <= '0;
    end else begin
      if (ifu_gnt_o)      tag_q <= TAG_IFU;
      else if (lsu_mem)   tag_q <= TAG_LSU;
      else if (lsu_gnt_o) tag_q <= TAG_ERR;
      else                tag_q <= TAG_NONE;

      if (mem_en_o) addr_q <= mem_addr_o;

      // Capture the returned word so rdata holds once rvalid drops.
      case (tag_q)
        TAG_IFU: ifu_hold <= mem_data_i;
        TAG_LSU: lsu_hold <= mem_data_i;
        TAG_ERR: lsu_hold <= '0;
        default: ;
      endcase
    end
  end

  // Reset squashes any response still in flight.
  always_comb begin
    ifu_rvalid_o = !rst_i && (tag_q == TAG_IFU);
    lsu_rvalid_o = !rst_i && ((tag_q == TAG_LSU) || (tag_q == TAG_ERR));
    lsu_err_o    = !rst_i && (tag_q == TAG_ERR);
    ifu_rdata_o  = ifu_rvalid_o ? mem_data_i : ifu_hold;
    if (lsu_err_o)         lsu_rdata_o = '0;
    else if (lsu_rvalid_o) lsu_rdata_o = mem_data_i;
    else                   lsu_rdata_o = lsu_hold;
  end

endmodule
